register_file: RTL and testbench

- General-purpose integer register file for the processor datapath: 32 entries x 32 bits.
- Two combinational read ports (A1/RD1, A2/RD2) feed the ALU operands.
- One synchronous write port (A3/WD) is driven by the write-back stage.
- Register 0 is hardwired to zero (RISC-V x0 convention).

---
 rtl/register_file_if.sv | 27 ++
 rtl/register_file.sv | 65 ++++++
 tb/tb_register_file.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Register file bus: write-back write port plus two ALU operand read ports.
// The master drives addresses, write data and write qualifiers.
// The slave (the register file) returns read data.
`timescale 1ns/10ps
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  EN;
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] A3;
  logic [DATA_WIDTH-1:0] WD;
  logic [ADDR_WIDTH-1:0] A1;
  logic [ADDR_WIDTH-1:0] A2;
  logic [DATA_WIDTH-1:0] RD1;
  logic [DATA_WIDTH-1:0] RD2;

  modport master (
    output EN, RegWrite, A3, WD, A1, A2,
    input  RD1, RD2
  );

  modport slave (
    input  EN, RegWrite, A3, WD, A1, A2,
    output RD1, RD2
  );
endinterface

// File: rtl/register_file.sv
// General-purpose integer register file, 2**ADDR_WIDTH x DATA_WIDTH.
// It has two combinational read ports and one rising-edge write port.
// Entry 0 reads as zero and ignores writes.
// RST clears every entry asynchronously and overrides any write on the same edge.
// Reads have no write-through bypass: a read returns the stored value until the edge.
`timescale 1ns/10ps
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic           CLK,
  input  logic           RST,
  register_file_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic                  w_we;
  logic                  w_a3_zero;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  // Writes to entry 0 are dropped so that it stays hardwired to zero.
  assign w_a3_zero = (bus.A3 == {ADDR_WIDTH{1'b0}});
  assign w_we      = bus.EN & bus.RegWrite & ~w_a3_zero;

  // Storage: async clear on RST, otherwise a qualified write of WD into entry A3.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      r_regs[0] <= {DATA_WIDTH{1'b0}};
      if (w_we) begin
        r_regs[bus.A3] <= bus.WD;
      end
    end
  end

  // Read port 1: zero-latency lookup, and address 0 is forced to zero.
  always_comb begin
    w_rd1 = {DATA_WIDTH{1'b0}};
    if (bus.A1 == {ADDR_WIDTH{1'b0}}) begin
      w_rd1 = {DATA_WIDTH{1'b0}};
    end else begin
      w_rd1 = r_regs[bus.A1];
    end
  end

  // Read port 2: zero-latency lookup, and address 0 is forced to zero.
  always_comb begin
    w_rd2 = {DATA_WIDTH{1'b0}};
    if (bus.A2 == {ADDR_WIDTH{1'b0}}) begin
      w_rd2 = {DATA_WIDTH{1'b0}};
    end else begin
      w_rd2 = r_regs[bus.A2];
    end
  end

  assign bus.RD1 = w_rd1;
  assign bus.RD2 = w_rd2;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file.
// Stimulus pushes the expected read data and raises a sample event.
// A separate monitor pops each expectation and compares it against RD1/RD2.
`timescale 1ns/10ps
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    string          name;
    logic [DW-1:0]  e1;
    logic [DW-1:0]  e2;
  } exp_t;

  logic CLK;
  logic RST;
  register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  exp_t q[$];
  event sample_ev;
  int   n_cmp = 0;
  int   n_err = 0;

  initial CLK = 1'b0;
  always #1 CLK = ~CLK;

  // Monitor: on every sample request, drain the scoreboard against the read ports.
  initial begin
    forever begin
      @(sample_ev);
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        if (bus.RD1 !== e.e1 || bus.RD2 !== e.e2) begin
          n_err++;
          $display("FAIL %s: RD1=%h RD2=%h expected RD1=%h RD2=%h at %0t",
                   e.name, bus.RD1, bus.RD2, e.e1, e.e2, $time);
        end
      end
    end
  end

  // Set the read addresses, then let the monitor check the expected data.
  task automatic check(input string name, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    exp_t e;
    bus.A1 = a1;
    bus.A2 = a2;
    #0.1;
    e.name = name;
    e.e1   = e1;
    e.e2   = e2;
    q.push_back(e);
    -> sample_ev;
    #0.05;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s: scoreboard not drained, %0d pending, expected 0", name, q.size());
      q.delete();
    end
  endtask

  // Watchdog: stop with an error if the run does not finish in time.
  initial begin
    #20000;
    $display("FAIL watchdog: run still active at %0t, expected to finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1;
    bus.EN = 1'b0;
    bus.RegWrite = 1'b0;
    bus.A3 = 5'd0;
    bus.WD = 32'd0;
    bus.A1 = 5'd0;
    bus.A2 = 5'd0;

    // Reset sweep: all entries read 0 while RST is held.
    for (int a = 0; a < 32; a++) begin
      #3;
      check("reset_sweep", a[AW-1:0], 5'(31 - a), 32'd0, 32'd0);
    end
    @(negedge CLK);
    RST = 1'b0;

    // Write sweep: before the edge the old value (0) is returned, after it the new value.
    bus.EN = 1'b1;
    bus.RegWrite = 1'b1;
    for (int j = 0; j < 32; j++) begin
      @(negedge CLK);
      bus.A3 = j[AW-1:0];
      bus.WD = 32'(j);
      check("wr_before_edge", j[AW-1:0], j[AW-1:0], 32'd0, 32'd0);
      @(posedge CLK);
      #0.2;
      check("wr_after_edge", j[AW-1:0], j[AW-1:0], 32'(j), 32'(j));
    end

    // Readback of pairs with writes disabled.
    @(negedge CLK);
    bus.RegWrite = 1'b0;
    for (int j = 0; j < 32; j += 2) begin
      #10;
      check("readback", j[AW-1:0], 5'(j + 1), 32'(j), 32'(j + 1));
    end

    // Overwrite registers 5 and 10, then check them and their neighbours.
    @(negedge CLK);
    bus.RegWrite = 1'b1;
    bus.A3 = 5'd5;
    bus.WD = 32'd10;
    #10;
    bus.A3 = 5'd10;
    bus.WD = 32'd20;
    #10;
    bus.RegWrite = 1'b0;
    check("overwrite", 5'd5, 5'd10, 32'd10, 32'd20);
    check("neighbours_4_6", 5'd4, 5'd6, 32'd4, 32'd6);
    check("neighbours_9_11", 5'd9, 5'd11, 32'd9, 32'd11);

    // Only the values present at the rising edge are written.
    @(posedge CLK);
    #0.2;
    bus.RegWrite = 1'b1;
    bus.A3 = 5'd14;
    bus.WD = 32'h0000_0055;
    #1.3;
    bus.A3 = 5'd15;
    bus.WD = 32'h0000_0066;
    @(posedge CLK);
    #0.2;
    bus.RegWrite = 1'b0;
    check("edge_sample", 5'd14, 5'd15, 32'd14, 32'h0000_0066);

    // EN=0 blocks writes.
    bus.EN = 1'b0;
    bus.RegWrite = 1'b1;
    bus.A3 = 5'd7;
    bus.WD = 32'hDEAD_BEEF;
    repeat (3) @(posedge CLK);
    #0.2;
    check("en_gate", 5'd7, 5'd7, 32'd7, 32'd7);

    // RegWrite=0 blocks writes.
    bus.EN = 1'b1;
    bus.RegWrite = 1'b0;
    bus.A3 = 5'd8;
    bus.WD = 32'h1234_5678;
    repeat (3) @(posedge CLK);
    #0.2;
    check("regwrite_gate", 5'd8, 5'd7, 32'd8, 32'd7);

    // Writes to x0 are ignored.
    bus.RegWrite = 1'b1;
    bus.A3 = 5'd0;
    bus.WD = 32'hFFFF_FFFF;
    repeat (2) @(posedge CLK);
    #0.2;
    bus.RegWrite = 1'b0;
    check("x0_write", 5'd0, 5'd0, 32'd0, 32'd0);
    check("x0_others", 5'd31, 5'd1, 32'd31, 32'd1);

    // Async reset between edges clears immediately, and a write during reset is lost.
    @(negedge CLK);
    #0.3;
    bus.RegWrite = 1'b1;
    bus.A3 = 5'd3;
    bus.WD = 32'h0000_AAAA;
    RST = 1'b1;
    check("async_rst_immediate", 5'd5, 5'd31, 32'd0, 32'd0);
    @(posedge CLK);
    #0.2;
    check("async_rst_write_blocked", 5'd3, 5'd10, 32'd0, 32'd0);
    @(negedge CLK);
    bus.RegWrite = 1'b0;
    RST = 1'b0;
    for (int a = 0; a < 32; a++) begin
      check("post_rst_sweep", a[AW-1:0], 5'(31 - a), 32'd0, 32'd0);
    end

    // The register file accepts writes again after reset.
    @(negedge CLK);
    bus.RegWrite = 1'b1;
    bus.A3 = 5'd9;
    bus.WD = 32'h0000_1234;
    @(posedge CLK);
    #0.2;
    bus.RegWrite = 1'b0;
    check("post_rst_write", 5'd9, 5'd8, 32'h0000_1234, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
